// File: rtl/foc_frontend_hls_deadlock_reporter_if.sv
// Report channel of the foc_frontend deadlock reporter: a valid/ready handshake
// carrying the first confirmed deadlock record (index, mask, timestamp).
interface foc_frontend_hls_deadlock_reporter_if #(
  parameter int unsigned NUM_MON = 4
);
  logic               rpt_valid;
  logic               rpt_ready;
  logic [3:0]         rpt_idx;
  logic [NUM_MON-1:0] rpt_mask;
  logic [31:0]        rpt_time;

  // Producer side: the reporter drives the record, the consumer drives ready.
  modport master (
    output rpt_valid,
    output rpt_idx,
    output rpt_mask,
    output rpt_time,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_idx,
    input  rpt_mask,
    input  rpt_time,
    output rpt_ready
  );
endinterface

// File: rtl/foc_frontend_hls_deadlock_reporter.sv
// Deadlock reporter for the foc_frontend monitors. Each monitor's block flag is
// filtered by a persistence counter; the first run reaching THRESH cycles is
// latched as a record (lowest index, mask snapshot, timestamp), offered once on
// the report handshake, and kept behind a sticky flag until clear.
// Optional feature macro: FOC_DEADLOCK_TIMESTAMP_EN builds the free-running
// timestamp counter and the rpt_time capture register; otherwise rpt_time is 0.
module foc_frontend_hls_deadlock_reporter #(
  parameter int unsigned NUM_MON = 4,
  parameter int unsigned THRESH  = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                                     clock,
  input  logic                                     reset_n,
  input  logic [NUM_MON-1:0]                       block_sigs,
  input  logic                                     clear,
  output logic                                     dl_flag,
  foc_frontend_hls_deadlock_reporter_if.master     rpt
);

  localparam logic [CNT_W-1:0] ThreshC  = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] ThreshM1 = CNT_W'(THRESH - 1);

  typedef enum logic [1:0] {
    StWatch  = 2'd0,
    StReport = 2'd1,
    StHold   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]   cnt_q [NUM_MON];
  logic [CNT_W-1:0]   cnt_d [NUM_MON];
  logic [NUM_MON-1:0] confirm_vec;
  logic               confirm_take;
  logic [3:0]         first_idx;

  logic               dl_flag_q, dl_flag_d;
  logic               valid_q, valid_d;
  logic [3:0]         idx_q, idx_d;
  logic [NUM_MON-1:0] mask_q, mask_d;

  // A monitor confirms on its THRESH-th consecutive asserted cycle.
  always_comb begin
    confirm_vec = '0;
    for (int i = 0; i < int'(NUM_MON); i++) begin
      confirm_vec[i] = (state_q == StWatch) && block_sigs[i] && (cnt_q[i] == ThreshM1);
    end
  end

  // Clear wins over a same-cycle confirm: the record is simply not taken.
  assign confirm_take = (|confirm_vec) && !clear;

  // Lowest confirming index wins a tie.
  always_comb begin
    first_idx = 4'd0;
    for (int i = int'(NUM_MON) - 1; i >= 0; i--) begin
      if (confirm_vec[i]) first_idx = 4'(i);
    end
  end

  // Persistence counters: count while asserted in WATCH, else held at zero.
  always_comb begin
    for (int i = 0; i < int'(NUM_MON); i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear || (state_q != StWatch) || (|confirm_vec) || !block_sigs[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != ThreshC) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_MON); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_MON); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Next-state and record logic; clear overrides everything.
  always_comb begin
    state_d   = state_q;
    dl_flag_d = dl_flag_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    if (clear) begin
      state_d   = StWatch;
      dl_flag_d = 1'b0;
      valid_d   = 1'b0;
      idx_d     = 4'd0;
      mask_d    = '0;
    end else begin
      unique case (state_q)
        StWatch: begin
          if (confirm_take) begin
            state_d   = StReport;
            dl_flag_d = 1'b1;
            valid_d   = 1'b1;
            idx_d     = first_idx;
            mask_d    = block_sigs;
          end
        end
        StReport: begin
          if (rpt.rpt_ready) begin
            state_d = StHold;
            valid_d = 1'b0;
          end
        end
        StHold: begin
          state_d = StHold;
        end
        default: begin
          state_d = StWatch;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and record registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StWatch;
      dl_flag_q <= 1'b0;
      valid_q   <= 1'b0;
      idx_q     <= 4'd0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      dl_flag_q <= dl_flag_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
    end
  end

`ifdef FOC_DEADLOCK_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] time_q;

  // Free-running cycle counter since reset, saturating; clear leaves it alone.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_q <= '0;
    end else if (ts_q != 32'hFFFF_FFFF) begin
      ts_q <= ts_q + 32'd1;
    end
  end

  // Timestamp captured on the confirming edge; survives clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      time_q <= '0;
    end else if (confirm_take) begin
      time_q <= ts_q;
    end
  end

  assign rpt.rpt_time = time_q;
`else
  assign rpt.rpt_time = 32'd0;
`endif

  assign dl_flag       = dl_flag_q;
  assign rpt.rpt_valid = valid_q;
  assign rpt.rpt_idx   = idx_q;
  assign rpt.rpt_mask  = mask_q;

endmodule

// File: doc/foc_frontend_hls_deadlock_reporter.md
# foc_frontend_hls_deadlock_reporter

Consumes the per-instance `block` flags produced by the foc_frontend deadlock monitors (one per monitored sub-instance, for example the torque_foc instance). It filters transient stalls with a per-monitor persistence counter and latches the first confirmed deadlock: which monitor fired, the full mask, and an optional timestamp. It presents that record once over a valid/ready handshake and raises a sticky flag until software clears it.

## Interface
- `NUM_MON`, 4: number of monitor `block` inputs (1–16).
- `THRESH`, 1024: consecutive asserted cycles required to confirm a deadlock (2–65535).
- `CNT_W`, 16: persistence counter width; must hold `THRESH`.
- `clock` input 1: single clock; all logic on rising edge.
- `reset_n` input 1: asynchronous active-low reset.
- `block_sigs` input NUM_MON: bit i = `block` output of monitor idx i; level, already registered.
- `clear` input 1: single-cycle pulse; re-arms the block.
- `dl_flag` output 1: sticky deadlock confirmed.
- `rpt_valid` output 1: report record available.
- `rpt_ready` input 1: consumer accepts the record.
- `rpt_idx` output 4: lowest index whose counter reached `THRESH`.
- `rpt_mask` output NUM_MON: snapshot of `block_sigs` in the confirm cycle.
- `rpt_time` output 32: cycles since reset at confirm.

## Operation
- One persistence counter per monitor:
  - Increments while its `block_sigs` bit is 1, saturating at `THRESH`.
  - Synchronously returns to 0 in any cycle its bit is 0.
  - Counters run only in state WATCH; in any other state they hold 0.
- State machine WATCH, REPORT, HOLD.
  - WATCH -> REPORT when any counter equals `THRESH - 1` and its bit is still 1, i.e. the `THRESH`-th consecutive asserted cycle. On that edge, latch `rpt_idx` (lowest such index), `rpt_mask` (current `block_sigs`) and `rpt_time`, and set `dl_flag`.
  - REPORT: `rpt_valid`=1, record stable. Moves to HOLD on the cycle `rpt_valid & rpt_ready`.
  - HOLD: `rpt_valid`=0, `dl_flag` stays 1, record registers keep their values.
  - `clear` in any state returns to WATCH the next cycle. It zeroes the counters, `dl_flag`, `rpt_valid`, `rpt_idx` and `rpt_mask`. `rpt_time` keeps its value.
  - `clear` takes priority over a simultaneous confirm or handshake. The record is discarded and no detection happens in that cycle.
- Simultaneous confirms in one cycle: the lowest index wins, and the mask records all asserted bits.
- After confirm, further block activity is ignored until `clear`.
- Timestamp counter: 32-bit, free-running from reset, saturating at 0xFFFFFFFF; `clear` does not reset it.

## Timing
- Reset values: `dl_flag`=0, `rpt_valid`=0, `rpt_idx`=0, `rpt_mask`=0, `rpt_time`=0; state WATCH; all counters 0.
- Detection latency: a `block_sigs` bit that is 1 for exactly `THRESH` consecutive cycles starting at cycle t gives `dl_flag`=`rpt_valid`=1 at cycle t+`THRESH`.
- A run of `THRESH-1` consecutive cycles never triggers.
- Handshake:
  - `rpt_valid` stays asserted and the record stays stable until accepted.
  - `rpt_ready` may be high before `rpt_valid`; acceptance then happens in the first valid cycle.
  - `rpt_valid` is never combinationally dependent on `rpt_ready`.
- `clear` asserted for multiple cycles holds WATCH with counters at 0.
- Asynchronous reset mid-REPORT drops `rpt_valid` immediately; the record is lost.
- All outputs are registered.

## Configuration
- `FOC_DEADLOCK_TIMESTAMP_EN` defined: the 32-bit timestamp counter and the `rpt_time` capture register are built.
- `FOC_DEADLOCK_TIMESTAMP_EN` undefined: counter and register are removed, `rpt_time` is tied to 0, and all other behaviour is identical.

## Test plan
- Pulse filtering (`THRESH`=8): `block_sigs[1]` high for 7 cycles, low for 1, then high for 7 -> `dl_flag` stays 0 throughout.
- Basic confirm (`THRESH`=8): `block_sigs[2]` held high from cycle 10 -> `dl_flag`=`rpt_valid`=1 at cycle 18 with `rpt_idx`=2 and `rpt_mask`=4'b0100. With the macro on, `rpt_time`=17.
- Tie-break: bits 3 and 1 rise in the same cycle -> `rpt_idx`=1 and `rpt_mask`=4'b1010.
- Backpressure: hold `rpt_ready`=0 for 20 cycles after confirm while `block_sigs` toggles -> record unchanged. Raise `rpt_ready` -> `rpt_valid` falls the next cycle and `dl_flag` stays 1.
- Clear priority: `clear` in the same cycle as the confirming edge -> `dl_flag`=0 and state WATCH. A fresh 8-cycle block then confirms normally.
- Reset mid-REPORT: drive `reset_n`=0 while `rpt_valid`=1 -> all outputs go to 0 asynchronously, and re-detection requires a full `THRESH` run.
